// File: rtl/ed25519_in_framer.sv
// Input framer for the ed25519 point-multiplication core: packs 64-bit words into
// 768-bit {M, x, y} frames held in ping-pong buffers. Optional macro: ED25519_RANGE_CHECK_EN.
module ed25519_in_framer #(
    parameter int WORD_W          = 64,
    parameter int WORDS_PER_FRAME = 12,
    parameter int BUF_DEPTH       = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_in_valid,
    input  logic [63:0]   i_in_data,
    output logic          o_in_ready,
    output logic          o_frame_valid,
    input  logic          i_frame_ready,
    output logic [255:0]  o_frame_m,
    output logic [255:0]  o_frame_x,
    output logic [255:0]  o_frame_y,
    output logic          o_frame_err,
    output logic [1:0]    o_occupancy
);

    localparam int FRAME_W = WORD_W * WORDS_PER_FRAME;

    logic [FRAME_W-1:0] r_buf [2];
    logic [1:0]         r_full;
    logic [3:0]         r_wcnt;
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_occ;
    logic               r_in_ready;

    logic               w_acc;
    logic               w_last;
    logic               w_pop;
    logic [1:0]         w_occ_nxt;
    logic [9:0]         w_lsb;

`ifdef ED25519_RANGE_CHECK_EN
    localparam logic [255:0] P_MOD = {4'h7, {61{4'hF}}, 8'hED};

    logic [1:0]   r_err;
    logic [255:0] w_x;
    logic [255:0] w_y;
    logic         w_err;

    function automatic logic range_err(input logic [255:0] x, input logic [255:0] y);
        return (x >= P_MOD) | (y >= P_MOD);
    endfunction

    // The final word is y's least-significant word, so y is completed from the live input.
    always_comb begin
        w_x   = r_buf[r_wptr][511:256];
        w_y   = {r_buf[r_wptr][255:64], i_in_data};
        w_err = range_err(w_x, w_y);
    end

    // Error flag stored alongside each completed frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 2'b00;
        end else if (i_flush) begin
            r_err <= 2'b00;
        end else if (w_last) begin
            r_err[r_wptr] <= w_err;
        end
    end

    assign o_frame_err = r_err[r_rptr] & r_full[r_rptr];
`else
    assign o_frame_err = 1'b0;
`endif

    // Handshake qualification; flush overrides both the word and the frame handshake.
    always_comb begin
        w_acc     = i_in_valid & r_in_ready & ~i_flush;
        w_last    = w_acc & (r_wcnt == 4'(WORDS_PER_FRAME - 1));
        w_pop     = r_full[r_rptr] & i_frame_ready & ~i_flush;
        w_occ_nxt = r_occ + {1'b0, w_last} - {1'b0, w_pop};
        w_lsb     = 10'(FRAME_W - WORD_W) - 10'(WORD_W) * 10'(r_wcnt);
    end

    // Frame storage: word k lands most-significant first; no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r_buf[r_wptr][w_lsb +: WORD_W] <= i_in_data;
        end
    end

    // Word counter, buffer pointers, occupancy and registered input ready.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full     <= 2'b00;
            r_wcnt     <= 4'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
            r_in_ready <= 1'b0;
        end else if (i_flush) begin
            r_full     <= 2'b00;
            r_wcnt     <= 4'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_acc) begin
                r_wcnt <= w_last ? 4'd0 : r_wcnt + 4'd1;
            end
            if (w_last) begin
                r_full[r_wptr] <= 1'b1;
                r_wptr         <= (BUF_DEPTH == 2) ? ~r_wptr : 1'b0;
            end
            if (w_pop) begin
                r_full[r_rptr] <= 1'b0;
                r_rptr         <= (BUF_DEPTH == 2) ? ~r_rptr : 1'b0;
            end
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt < 2'(BUF_DEPTH));
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_frame_valid = r_full[r_rptr];
    assign o_frame_m     = r_buf[r_rptr][767:512];
    assign o_frame_x     = r_buf[r_rptr][511:256];
    assign o_frame_y     = r_buf[r_rptr][255:0];
    assign o_occupancy   = r_occ;

endmodule

// File: tb/tb_ed25519_in_framer.sv
// Bench for ed25519_in_framer: queue-based frame model checked every cycle plus
// directed literal expectations for each scenario.
module tb_ed25519_in_framer;

    localparam logic [255:0] P_MOD = {4'h7, {61{4'hF}}, 8'hED};
`ifdef ED25519_RANGE_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [63:0]  in_data = 64'd0;
    logic         frame_ready = 1'b0;
    logic         in_ready;
    logic         frame_valid;
    logic [255:0] frame_m, frame_x, frame_y;
    logic         frame_err;
    logic [1:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;

    ed25519_in_framer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_in_valid    (in_valid),
        .i_in_data     (in_data),
        .o_in_ready    (in_ready),
        .o_frame_valid (frame_valid),
        .i_frame_ready (frame_ready),
        .o_frame_m     (frame_m),
        .o_frame_x     (frame_x),
        .o_frame_y     (frame_y),
        .o_frame_err   (frame_err),
        .o_occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a queue of completed frames, a partial frame and a ready flag.
    logic [767:0] m_q [$];
    logic         m_eq [$];
    logic [767:0] m_part = 768'd0;
    int           m_cnt = 0;
    logic         m_ready = 1'b0;

    function automatic logic exp_err(input logic [767:0] f);
        return ERR_ON & ((f[511:256] >= P_MOD) | (f[255:0] >= P_MOD));
    endfunction

    // Compare against the model at each falling edge, then advance the model with
    // the inputs that the next rising edge will consume.
    initial begin
        forever begin
            logic acc, pop;
            @(negedge clk);
            if (!rst_n) begin
                m_q.delete();
                m_eq.delete();
                m_cnt   = 0;
                m_ready = 1'b0;
            end
            chk("in_ready", 256'(in_ready), 256'(m_ready));
            chk("frame_valid", 256'(frame_valid), 256'(m_q.size() > 0));
            chk("occupancy", 256'(occupancy), 256'(m_q.size()));
            if (m_q.size() > 0) begin
                chk("frame_m", frame_m, m_q[0][767:512]);
                chk("frame_x", frame_x, m_q[0][511:256]);
                chk("frame_y", frame_y, m_q[0][255:0]);
                chk("frame_err", 256'(frame_err), 256'(m_eq[0]));
            end
            if (rst_n) begin
                acc = in_valid && m_ready && !flush;
                pop = (m_q.size() > 0) && frame_ready && !flush;
                if (flush) begin
                    m_q.delete();
                    m_eq.delete();
                    m_cnt = 0;
                end else begin
                    if (pop) begin
                        void'(m_q.pop_front());
                        void'(m_eq.pop_front());
                    end
                    if (acc) begin
                        m_part[(767 - 64 * m_cnt) -: 64] = in_data;
                        m_cnt++;
                        if (m_cnt == 12) begin
                            m_q.push_back(m_part);
                            m_eq.push_back(exp_err(m_part));
                            m_cnt = 0;
                        end
                    end
                end
                m_ready = (m_q.size() < 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until the framer takes it (leaves valid asserted).
    task automatic put_word(input logic [63:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL put_word_timeout: got ready=0 after %0d cycles expected ready=1", n);
        end
        tick();
    endtask

    task automatic send_frame(input logic [63:0] base);
        for (int i = 0; i < 12; i++) put_word(base + 64'(i));
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [767:0] f);
        for (int i = 0; i < 12; i++) put_word(f[(767 - 64 * i) -: 64]);
        in_valid = 1'b0;
    endtask

    task automatic drain_one();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
    endtask

    initial begin
        logic [767:0] f;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
        chk("rst_valid", 256'(frame_valid), 256'(1'b0));
        chk("rst_occ", 256'(occupancy), 256'(2'd0));
        chk("rst_err", 256'(frame_err), 256'(1'b0));
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 256'(in_ready), 256'(1'b1));

        // Single frame with the core always ready
        frame_ready = 1'b1;
        send_frame(64'h1);
        chk("single_valid", 256'(frame_valid), 256'(1'b1));
        chk("single_m_top", 256'(frame_m[255:192]), 256'(64'h1));
        chk("single_y_low", 256'(frame_y[63:0]), 256'(64'hC));
        tick();
        chk("single_valid_drop", 256'(frame_valid), 256'(1'b0));
        frame_ready = 1'b0;

        // Backpressure: two frames buffered, third frame's word 0 held
        send_frame(64'h100);
        send_frame(64'h200);
        in_valid = 1'b1;
        in_data  = 64'h300;
        tick();
        tick();
        chk("bp_occ_full", 256'(occupancy), 256'(2'd2));
        chk("bp_ready_low", 256'(in_ready), 256'(1'b0));
        chk("bp_first_frame", 256'(frame_m[255:192]), 256'(64'h100));
        drain_one();
        chk("bp_ready_rise", 256'(in_ready), 256'(1'b1));
        chk("bp_second_frame", 256'(frame_m[255:192]), 256'(64'h200));
        send_frame(64'h300);
        chk("bp_occ_again", 256'(occupancy), 256'(2'd2));
        drain_one();
        chk("bp_third_frame", 256'(frame_m[255:192]), 256'(64'h300));
        drain_one();
        chk("bp_empty", 256'(frame_valid), 256'(1'b0));

        // Simultaneous completion and consumption
        send_frame(64'h400);
        for (int i = 0; i < 11; i++) put_word(64'h500 + 64'(i));
        in_data     = 64'h50B;
        frame_ready = 1'b1;
        tick();
        in_valid    = 1'b0;
        frame_ready = 1'b0;
        chk("sim_occ", 256'(occupancy), 256'(2'd1));
        chk("sim_valid", 256'(frame_valid), 256'(1'b1));
        chk("sim_next_frame", 256'(frame_m[255:192]), 256'(64'h500));
        drain_one();

        // Flush with one buffered frame and a partial frame; word and handshake dropped
        send_frame(64'h600);
        for (int i = 0; i < 5; i++) put_word(64'h700 + 64'(i));
        flush       = 1'b1;
        frame_ready = 1'b1;
        in_data     = 64'hDEAD;
        tick();
        flush       = 1'b0;
        frame_ready = 1'b0;
        in_valid    = 1'b0;
        chk("flush_valid", 256'(frame_valid), 256'(1'b0));
        chk("flush_occ", 256'(occupancy), 256'(2'd0));
        chk("flush_ready", 256'(in_ready), 256'(1'b1));
        send_frame(64'h800);
        chk("flush_fresh_valid", 256'(frame_valid), 256'(1'b1));
        chk("flush_fresh_m_top", 256'(frame_m[255:192]), 256'(64'h800));
        chk("flush_fresh_occ", 256'(occupancy), 256'(2'd1));
        drain_one();

        // Range check vectors
        f = {256'h1234, P_MOD, 256'd0};
        send_vec(f);
        chk("range_x_eq_p", 256'(frame_err), 256'(ERR_ON));
        drain_one();
        f = {256'h1234, P_MOD - 256'd1, 256'd0};
        send_vec(f);
        chk("range_x_p_minus_1", 256'(frame_err), 256'(1'b0));
        drain_one();
        f = {256'd0, 256'd5, P_MOD};
        send_vec(f);
        chk("range_y_eq_p", 256'(frame_err), 256'(ERR_ON));
        drain_one();

        // Asynchronous reset with both buffers full
        send_frame(64'h900);
        send_frame(64'hA00);
        chk("ar_occ_full", 256'(occupancy), 256'(2'd2));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ready", 256'(in_ready), 256'(1'b0));
        chk("ar_valid", 256'(frame_valid), 256'(1'b0));
        chk("ar_occ", 256'(occupancy), 256'(2'd0));
        chk("ar_err", 256'(frame_err), 256'(1'b0));
        tick();
        #2 rst_n = 1'b1;
        tick();
        chk("ar_rel_ready", 256'(in_ready), 256'(1'b1));
        chk("ar_rel_valid", 256'(frame_valid), 256'(1'b0));
        repeat (3) tick();
        chk("ar_no_ghost", 256'(frame_valid), 256'(1'b0));
        frame_ready = 1'b1;
        send_frame(64'hB00);
        chk("ar_after_frame", 256'(frame_m[255:192]), 256'(64'hB00));
        repeat (3) tick();
        frame_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL global_timeout: got no finish expected finish before 500000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ed25519_in_framer.md
Name: ed25519_in_framer

Overview:
- Upstream stage of the ed25519 point-multiplication core.
- Deserialises the 64-bit input stream into 768-bit job frames: scalar M, then point x, then point y.
- Holds up to two complete frames in ping-pong buffers, so the next job loads while the core computes.
- Presents each frame to the core through a valid/ready frame handshake.

Parameters:
- WORD_W, 64, input word width in bits; fixed at 64 for this design.
- WORDS_PER_FRAME, 12, words per job frame (3 x 256 / 64).
- BUF_DEPTH, 2, number of frame buffers; legal values are 1 and 2.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_flush  input  1  synchronous discard of the partial frame and all buffered frames.
- i_in_valid  input  1  input word valid.
- i_in_data  input  64  input word.
- o_in_ready  output  1  framer can accept a word this cycle.
- o_frame_valid  output  1  a complete frame is presented.
- i_frame_ready  input  1  core accepts the presented frame.
- o_frame_m  output  256  scalar M of the presented frame.
- o_frame_x  output  256  x of the presented frame.
- o_frame_y  output  256  y of the presented frame.
- o_frame_err  output  1  range flag for the presented frame (see Optional Feature).
- o_occupancy  output  2  number of complete frames held, 0..BUF_DEPTH.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - o_in_ready=0, o_frame_valid=0, o_frame_err=0, o_occupancy=0.
  - Word counter, write pointer and read pointer all cleared.
  - Frame data registers need no reset; the frame outputs are don't-care while o_frame_valid=0.
  - First cycle after release: o_in_ready=1.
- Reset mid-frame: partial and buffered frames are lost; no frame is emitted afterwards.
- Word order within a frame:
  - Word k (k=0..11) lands in frame bits [767-64k -: 64].
  - M=[767:512], x=[511:256], y=[255:0]; most-significant word first.
- Accept rule: a word is taken on a cycle where i_in_valid & o_in_ready.
  - The word counter 0..11 increments on each accepted word.
  - On the 12th word the counter wraps to 0, the write buffer is marked full, and the write pointer toggles (BUF_DEPTH=2).
- o_in_ready is registered: 1 iff occupancy after the current cycle's updates is below BUF_DEPTH.
  - There is no combinational path from i_frame_ready or i_in_valid to o_in_ready.
  - Both buffers full and a frame is consumed in cycle t: o_in_ready rises at t+1.
  - Filling the last free buffer in cycle t: o_in_ready is 0 from t+1.
- Latency: o_frame_valid=1 in the cycle after the 12th word is accepted, provided that buffer is next to be read.
- o_frame_valid = read buffer full.
  - o_frame_m/x/y are driven from the read buffer and are stable while valid & !ready.
  - On valid & ready the buffer is freed and the read pointer toggles.
  - With the next buffer already full, valid stays 1 and the data switches to that frame next cycle.
- Simultaneous completion of a write frame and consumption of a read frame in one cycle: occupancy stays unchanged and both pointers toggle.
- Occupancy never exceeds BUF_DEPTH and never underflows. Words arriving while o_in_ready=0 are not taken; upstream holds them.
- i_flush has priority over all events in its cycle:
  - occupancy, word counter and pointers go to 0.
  - o_frame_valid=0 next cycle.
  - A word presented in the flush cycle is dropped, as is a frame handshake in the flush cycle.
  - o_in_ready=1 next cycle.

Optional Feature:
- Macro: ED25519_RANGE_CHECK_EN.
- Defined:
  - At frame completion, compute err = (x >= p) | (y >= p), where p = 2^255-19 = 0x7FFF...FFED.
  - Store err alongside the frame; o_frame_err is valid with o_frame_valid.
  - The frame is still delivered unmodified; the core decides how to handle it.
  - Latency is unchanged.
- Undefined: o_frame_err is tied to 0 and no comparator logic is built.

Test Plan:
- Single frame: words 0x0000_0000_0000_0001..0x0000_0000_0000_000C, back-to-back, i_frame_ready=1 -> o_frame_valid high one cycle after word 12; o_frame_m[255:192]=0x1, o_frame_y[63:0]=0xC; valid drops the cycle after the handshake.
- Backpressure: 3 frames streamed, i_frame_ready=0 -> o_occupancy reaches 2 and o_in_ready=0 while the 3rd frame's word 0 is held. Then i_frame_ready=1 for one cycle -> o_in_ready=1 next cycle; frames emerge in order 1, 2, 3.
- Simultaneous events: occupancy=1, 12th word of the next frame accepted in the same cycle as a frame handshake -> o_occupancy stays 1 and the following frame is presented next cycle.
- Flush: i_flush pulsed after 5 words, then 12 fresh words -> only the fresh frame is emitted, with its word 0 at M[255:192].
- Async reset: i_rst_n low mid-frame with occupancy=2 -> all outputs 0 immediately; after release o_in_ready=1 and o_frame_valid=0.
- With ED25519_RANGE_CHECK_EN: x = 2^255-19 -> o_frame_err=1; x = 2^255-20 and y = 0 -> o_frame_err=0. Without the macro -> o_frame_err=0 in both cases.
